// File: rtl/mem_arbiter_if.sv
// Pipeline-side (IF/ME) and external-bus signals of mem_arbiter.
// slave = arbiter side, master = pipeline + bus environment side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              iIF_req;
    logic [ADDR_W-1:0] iIF_addr;
    logic              iFlush_IF;
    logic              oIF_ack;
    logic [DATA_W-1:0] oIF_rdata;
    logic              iME_req;
    logic              iME_we;
    logic [ADDR_W-1:0] iME_addr;
    logic [DATA_W-1:0] iME_wdata;
    logic [BE_W-1:0]   iME_be;
    logic              oME_ack;
    logic [DATA_W-1:0] oME_rdata;
    logic              oStall_IF;
    logic              oStall_ME;
    logic              oBus_req;
    logic              oBus_we;
    logic [ADDR_W-1:0] oBus_addr;
    logic [DATA_W-1:0] oBus_wdata;
    logic [BE_W-1:0]   oBus_be;
    logic              iBus_ack;
    logic [DATA_W-1:0] iBus_rdata;
    logic              oBus_err;

    modport slave (
        input  iIF_req, iIF_addr, iFlush_IF,
        input  iME_req, iME_we, iME_addr, iME_wdata, iME_be,
        input  iBus_ack, iBus_rdata,
        output oIF_ack, oIF_rdata, oME_ack, oME_rdata,
        output oStall_IF, oStall_ME,
        output oBus_req, oBus_we, oBus_addr, oBus_wdata, oBus_be,
        output oBus_err
    );

    modport master (
        output iIF_req, iIF_addr, iFlush_IF,
        output iME_req, iME_we, iME_addr, iME_wdata, iME_be,
        output iBus_ack, iBus_rdata,
        input  oIF_ack, oIF_rdata, oME_ack, oME_rdata,
        input  oStall_IF, oStall_ME,
        input  oBus_req, oBus_we, oBus_addr, oBus_wdata, oBus_be,
        input  oBus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// IF/ME arbiter onto one single-port memory bus, ME priority with bounded streak.
// Define MEMARB_TIMEOUT_EN to abandon bus waits after TIMEOUT_CYCLES (oBus_err).
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ME_STREAK_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic          iClk,
    input logic          nRst,
    mem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int SW = (ME_STREAK_MAX > 0) ? $clog2(ME_STREAK_MAX + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(ME_STREAK_MAX);

    typedef enum logic [1:0] {IDLE, IF_BUS, ME_BUS, RESP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              kill_q, kill_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic              bus_err_q, bus_err_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              me_ack_q, me_ack_d;
    logic [DATA_W-1:0] me_rdata_q, me_rdata_d;
    logic              me_elig;
    logic              in_bus;
    logic              tmo_hit;
    logic [DATA_W-1:0] done_data;

    assign in_bus = (state_q == IF_BUS) || (state_q == ME_BUS);

`ifdef MEMARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = '0;
        if (in_bus) tmo_d = tmo_q + 1'b1;
    end

    assign tmo_hit = in_bus && !bus.iBus_ack &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iClk or posedge nRst) begin
        if (nRst) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    // A timed-out transfer completes with zero data.
    assign done_data = bus.iBus_ack ? bus.iBus_rdata : '0;

    assign me_elig = bus.iME_req &&
                     (!bus.iIF_req || (ME_STREAK_MAX == 0) ||
                      (streak_q < STREAK_MAX));

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        kill_d      = kill_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_err_d   = 1'b0;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        me_ack_d    = 1'b0;
        me_rdata_d  = me_rdata_q;
        if (!bus.iIF_req) streak_d = '0;
        unique case (state_q)
            IDLE: begin
                if (me_elig) begin
                    state_d     = ME_BUS;
                    bus_req_d   = 1'b1;
                    bus_we_d    = bus.iME_we;
                    bus_addr_d  = bus.iME_addr;
                    bus_wdata_d = bus.iME_wdata;
                    bus_be_d    = bus.iME_be;
                    if (bus.iIF_req && (streak_q < STREAK_MAX))
                        streak_d = streak_q + 1'b1;
                end else if (bus.iIF_req && !bus.iFlush_IF) begin
                    state_d    = IF_BUS;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = bus.iIF_addr;
                    bus_be_d   = '1;
                    streak_d   = '0;
                end
            end
            IF_BUS, ME_BUS: begin
                if (state_q == IF_BUS && bus.iFlush_IF) kill_d = 1'b1;
                if (bus.iBus_ack || tmo_hit) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    bus_err_d = tmo_hit;
                    if (state_q == IF_BUS) begin
                        if (!(kill_q || bus.iFlush_IF)) begin
                            if_ack_d   = 1'b1;
                            if_rdata_d = done_data;
                        end
                    end else begin
                        me_ack_d = 1'b1;
                        if (!bus_we_q || tmo_hit) me_rdata_d = done_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge nRst) begin
        if (nRst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            kill_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            bus_err_q   <= 1'b0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            me_ack_q    <= 1'b0;
            me_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            kill_q      <= kill_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_err_q   <= bus_err_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            me_ack_q    <= me_ack_d;
            me_rdata_q  <= me_rdata_d;
        end
    end

    assign bus.oIF_ack    = if_ack_q;
    assign bus.oIF_rdata  = if_rdata_q;
    assign bus.oME_ack    = me_ack_q;
    assign bus.oME_rdata  = me_rdata_q;
    assign bus.oStall_IF  = bus.iIF_req & ~if_ack_q;
    assign bus.oStall_ME  = bus.iME_req & ~me_ack_q;
    assign bus.oBus_req   = bus_req_q;
    assign bus.oBus_we    = bus_we_q;
    assign bus.oBus_addr  = bus_addr_q;
    assign bus.oBus_wdata = bus_wdata_q;
    assign bus.oBus_be    = bus_be_q;
    assign bus.oBus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a bus slave model and ack scoreboard.
// Define MEMARB_TIMEOUT_EN to also exercise the bus timeout (TIMEOUT_CYCLES=8).
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    typedef struct {
        bit          is_me;
        bit          chk_data;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic iClk = 1'b0;
    logic nRst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   bus_lat = 0;
    bit   bus_hang = 1'b0;
    int   bus_wait = 0;
    logic [31:0] mem [logic [31:0]];

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) intf ();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW),
        .ME_STREAK_MAX(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .iClk(iClk),
        .nRst(nRst),
        .bus (intf)
    );

    always #5 iClk = ~iClk;

    function automatic exp_t mk(bit m, bit c, bit e, logic [31:0] d);
        exp_t r;
        r.is_me = m; r.chk_data = c; r.err = e; r.data = d;
        return r;
    endfunction

    function automatic logic [31:0] rd_model(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_ack(input bit me, input int maxc);
        int n = 0;
        while (!(me ? intf.oME_ack : intf.oIF_ack) && n < maxc) begin
            step();
            n++;
        end
        chk(me ? "me_ack_wait" : "if_ack_wait",
            me ? intf.oME_ack : intf.oIF_ack, 1);
        if (me) intf.iME_req = 1'b0;
        else    intf.iIF_req = 1'b0;
        step();
    endtask

    // Bus slave: acks bus_lat cycles after oBus_req rises, mid-cycle.
    always @(negedge iClk) begin
        logic [31:0] w;
        intf.iBus_ack = 1'b0;
        if (nRst || !intf.oBus_req || bus_hang) begin
            bus_wait = 0;
        end else if (bus_wait < bus_lat) begin
            bus_wait++;
        end else begin
            bus_wait = 0;
            intf.iBus_ack = 1'b1;
            intf.iBus_rdata = intf.oBus_we ? 32'h0 : rd_model(intf.oBus_addr);
            if (intf.oBus_we) begin
                w = rd_model(intf.oBus_addr);
                for (int b = 0; b < BW; b++)
                    if (intf.oBus_be[b]) w[8*b +: 8] = intf.oBus_wdata[8*b +: 8];
                mem[intf.oBus_addr] = w;
            end
        end
    end

    // Scoreboard: every ack pops the next expected completion.
    always @(negedge iClk) begin
        if (!nRst) begin
            if (intf.oIF_ack || intf.oME_ack) begin
                if (sb.size() == 0) begin
                    chk("spurious_ack", {30'b0, intf.oIF_ack, intf.oME_ack}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_owner_me", intf.oME_ack, mon_e.is_me);
                    chk("ack_owner_if", intf.oIF_ack, !mon_e.is_me);
                    if (mon_e.chk_data)
                        chk("ack_rdata", mon_e.is_me ? intf.oME_rdata
                                                     : intf.oIF_rdata, mon_e.data);
                    chk("ack_bus_err", intf.oBus_err, mon_e.err);
                end
            end else if (intf.oBus_err) begin
                chk("stray_bus_err", intf.oBus_err, 0);
            end
        end
    end

    initial begin
        int n;
        intf.iIF_req = 0; intf.iIF_addr = '0; intf.iFlush_IF = 0;
        intf.iME_req = 0; intf.iME_we = 0; intf.iME_addr = '0;
        intf.iME_wdata = '0; intf.iME_be = '1;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h200] = 32'hAABBCCDD;

        step();
        chk("rst_bus_req", intf.oBus_req, 0);
        chk("rst_bus_addr", intf.oBus_addr, 0);
        chk("rst_bus_be", intf.oBus_be, 0);
        chk("rst_if_ack", intf.oIF_ack, 0);
        chk("rst_me_ack", intf.oME_ack, 0);
        chk("rst_me_rdata", intf.oME_rdata, 0);
        chk("rst_bus_err", intf.oBus_err, 0);
        nRst = 1'b0;
        step();

        // ME read, minimum latency
        sb.push_back(mk(1, 1, 0, 32'hDEADBEEF));
        intf.iME_req = 1; intf.iME_addr = 32'h100;
        #1;
        chk("t1_stall_c0", intf.oStall_ME, 1);
        chk("t1_busreq_c0", intf.oBus_req, 0);
        step();
        chk("t1_busreq_c1", intf.oBus_req, 1);
        chk("t1_addr_c1", intf.oBus_addr, 32'h100);
        chk("t1_we_c1", intf.oBus_we, 0);
        chk("t1_stall_c1", intf.oStall_ME, 1);
        chk("t1_ack_c1", intf.oME_ack, 0);
        step();
        chk("t1_ack_c2", intf.oME_ack, 1);
        chk("t1_rdata_c2", intf.oME_rdata, 32'hDEADBEEF);
        chk("t1_busreq_c2", intf.oBus_req, 0);
        chk("t1_stall_c2", intf.oStall_ME, 0);
        intf.iME_req = 0;
        step();
        chk("t1_ack_c3", intf.oME_ack, 0);

        // ME partial write with slow bus; fields latched
        bus_lat = 2;
        sb.push_back(mk(1, 0, 0, 32'h0));
        intf.iME_req = 1; intf.iME_we = 1; intf.iME_addr = 32'h200;
        intf.iME_wdata = 32'h11223344; intf.iME_be = 4'b0011;
        step();
        chk("t2_we", intf.oBus_we, 1);
        chk("t2_be", intf.oBus_be, 4'b0011);
        chk("t2_wdata", intf.oBus_wdata, 32'h11223344);
        intf.iME_addr = 32'h999; intf.iME_wdata = 32'h0;
        step();
        chk("t2_addr_frozen", intf.oBus_addr, 32'h200);
        chk("t2_wdata_frozen", intf.oBus_wdata, 32'h11223344);
        chk("t2_req_held", intf.oBus_req, 1);
        wait_ack(1, 20);
        bus_lat = 0;
        intf.iME_we = 0; intf.iME_be = '1; intf.iME_addr = 32'h200;
        sb.push_back(mk(1, 1, 0, 32'hAABB3344));
        intf.iME_req = 1;
        wait_ack(1, 20);

        // simultaneous IF and ME: ME first
        sb.push_back(mk(1, 1, 0, 32'hDEADBEEF));
        sb.push_back(mk(0, 1, 0, 32'h1000EFFF));
        intf.iME_addr = 32'h100; intf.iIF_addr = 32'h1000;
        intf.iME_req = 1; intf.iIF_req = 1;
        step();
        chk("t3_first_addr", intf.oBus_addr, 32'h100);
        for (int i = 0; i < 30 && intf.iIF_req; i++) begin
            if (intf.oME_ack) intf.iME_req = 0;
            if (intf.oIF_ack) intf.iIF_req = 0;
            if (intf.iIF_req) step();
        end
        chk("t3_if_done", intf.iIF_req, 0);
        step();

        // streak: ME x4, IF, ME x4, IF
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) sb.push_back(mk(1, 1, 0, 32'h0300FCFF));
            sb.push_back(mk(0, 1, 0, 32'h1004EFFB));
        end
        intf.iME_addr = 32'h300; intf.iIF_addr = 32'h1004;
        intf.iME_req = 1; intf.iIF_req = 1;
        n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            step();
            if (intf.oIF_ack || intf.oME_ack) n++;
        end
        intf.iME_req = 0; intf.iIF_req = 0;
        chk("t4_ack_count", n, 10);
        step();
        step();

        // flush in the bus-ack cycle kills the fetch
        bus_lat = 1;
        intf.iIF_addr = 32'h2000; intf.iIF_req = 1;
        step();
        chk("t5_busreq", intf.oBus_req, 1);
        chk("t5_if_be", intf.oBus_be, 4'hF);
        chk("t5_if_we", intf.oBus_we, 0);
        chk("t5_if_addr", intf.oBus_addr, 32'h2000);
        chk("t5_stall_if", intf.oStall_IF, 1);
        step();
        intf.iFlush_IF = 1;
        step();
        chk("t5_killed_ack", intf.oIF_ack, 0);
        chk("t5_busreq_resp", intf.oBus_req, 0);
        intf.iIF_addr = 32'h2004;
        step();
        chk("t5_killed_ack2", intf.oIF_ack, 0);
        step();
        chk("t5_flush_blocks", intf.oBus_req, 0);
        intf.iFlush_IF = 0;
        sb.push_back(mk(0, 1, 0, 32'h2004DFFB));
        wait_ack(0, 20);
        bus_lat = 0;

        // reset while ME_BUS
        bus_hang = 1;
        intf.iME_addr = 32'h400; intf.iME_req = 1;
        step();
        chk("t6_busreq", intf.oBus_req, 1);
        #2;
        nRst = 1'b1;
        #1;
        chk("t6_busreq_rst", intf.oBus_req, 0);
        intf.iME_req = 0;
        step();
        nRst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_ack", intf.oME_ack, 0);
            chk("t6_idle", intf.oBus_req, 0);
        end
        bus_hang = 0;
        sb.push_back(mk(1, 1, 0, 32'h0400FBFF));
        intf.iME_req = 1;
        wait_ack(1, 20);

`ifdef MEMARB_TIMEOUT_EN
        bus_hang = 1;
        sb.push_back(mk(1, 1, 1, 32'h0));
        intf.iME_addr = 32'h500; intf.iME_req = 1;
        n = 0;
        for (int i = 0; i < 30 && !intf.oME_ack; i++) begin
            step();
            if (intf.oBus_req) n++;
        end
        chk("t7_req_cycles", n, 8);
        chk("t7_ack", intf.oME_ack, 1);
        chk("t7_err", intf.oBus_err, 1);
        chk("t7_rdata", intf.oME_rdata, 0);
        intf.iME_req = 0;
        step();
        chk("t7_err_pulse", intf.oBus_err, 0);
        bus_hang = 0;
`endif

        step();
        step();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
